// File: rtl/spi_rx_if.sv
// rtl/spi_rx_if.sv - parallel word output handshake for spi_rx
interface spi_rx_if #(
    parameter int WIDTH = 12
) ();
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;

    modport master (output dout, output dout_valid, input dout_ready);
    modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/spi_rx.sv
// rtl/spi_rx.sv - LSB-first SPI frame receiver with valid/ready word output
// SPI_RX_SYNC2_EN selects a two-flop input synchroniser instead of one stage.
module spi_rx #(
    parameter int WIDTH = 12
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     sclk,
    input  logic     cs,
    input  logic     mosi,
    spi_rx_if.master out_if,
    output logic     busy,
    output logic     frame_err,
    output logic     overrun
);
`ifdef SPI_RX_SYNC2_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, WAIT_CS = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [D-1:0]     sclk_sync_q, sclk_sync_d;
    logic [D-1:0]     cs_sync_q, cs_sync_d;
    logic [D-1:0]     mosi_sync_q, mosi_sync_d;
    logic             sclk_dly_q, sclk_dly_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             sclk_s, cs_s, mosi_s, rise, last_bit;
    logic [WIDTH-1:0] word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            sclk_sync_q  <= '0;
            cs_sync_q    <= '1;
            mosi_sync_q  <= '0;
            sclk_dly_q   <= 1'b0;
            cnt_q        <= '0;
            shift_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sclk_dly_q   <= sclk_dly_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // Shifting left by one keeps the same expression valid for D=1 and D=2.
    always_comb begin
        sclk_sync_d = (sclk_sync_q << 1) | D'(sclk);
        cs_sync_d   = (cs_sync_q << 1) | D'(cs);
        mosi_sync_d = (mosi_sync_q << 1) | D'(mosi);
        sclk_s      = sclk_sync_q[D-1];
        cs_s        = cs_sync_q[D-1];
        mosi_s      = mosi_sync_q[D-1];
        sclk_dly_d  = sclk_s;
        rise        = sclk_s & ~sclk_dly_q;
        last_bit    = rise && (cnt_q == CW'(WIDTH - 1));
    end

    // A completing rise wins over a simultaneous cs release.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!cs_s) state_d = RECV;
            RECV: begin
                if (last_bit)  state_d = cs_s ? IDLE : WAIT_CS;
                else if (cs_s) state_d = IDLE;
            end
            WAIT_CS: if (cs_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q & ~out_if.dout_ready;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        word         = shift_q | (WIDTH'(mosi_s) << cnt_q);
        unique case (state_q)
            IDLE: begin
                if (!cs_s) begin
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            RECV: begin
                if (rise) begin
                    cnt_d   = cnt_q + CW'(1);
                    shift_d = word;
                    if (last_bit) begin
                        if (!dout_valid_q || out_if.dout_ready) begin
                            dout_d       = word;
                            dout_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end else if (cs_s) begin
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    shift_d     = '0;
                end
            end
            default: ;
        endcase
        busy              = (state_q != IDLE);
        frame_err         = frame_err_q;
        overrun           = overrun_q;
        out_if.dout       = dout_q;
        out_if.dout_valid = dout_valid_q;
    end
endmodule

// File: tb/tb_spi_rx.sv
// tb/tb_spi_rx.sv - directed and randomized frame checks for spi_rx
module tb_spi_rx;
    localparam int WIDTH = 12;
    localparam int PH    = 4;
`ifdef SPI_RX_SYNC2_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif

    logic clk = 1'b0;
    logic rst, sclk, cs, mosi;
    logic busy, frame_err, overrun;
    int   checks = 0;
    int   errors = 0;
    int   fe_cnt = 0;
    int   ov_cnt = 0;

    logic [WIDTH-1:0] exp_dout;
    logic             exp_valid;
    int               exp_fe, exp_ov;
    bit               rdy;

    spi_rx_if #(.WIDTH(WIDTH)) out_if ();

    spi_rx #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs        (cs),
        .mosi      (mosi),
        .out_if    (out_if),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_dout"}, 32'(out_if.dout), 32'(exp_dout));
        check({tag, "_valid"}, 32'(out_if.dout_valid), 32'(exp_valid));
        check({tag, "_frame_err"}, 32'(fe_cnt), 32'(exp_fe));
        check({tag, "_overrun"}, 32'(ov_cnt), 32'(exp_ov));
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Reference: a full frame yields a word unless the previous one is still held.
    task automatic model_frame(input logic [WIDTH-1:0] w, input int nbits, input bit rdy_done);
        if (rdy) exp_valid = 1'b0;
        if (nbits == WIDTH) begin
            if (!exp_valid || rdy_done) begin
                exp_dout  = w;
                exp_valid = 1'b1;
            end else begin
                exp_ov++;
            end
        end else begin
            exp_fe++;
        end
        if (rdy) exp_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input int nbits, input bit coincide,
                              input int extra, input bit chk_lat, input bit ready_pulse);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        cs = 1'b0;
        cyc(PH);
        for (int i = 0; i < nbits; i++) begin
            mosi = w[i];
            sclk = 1'b0;
            cyc(PH);
            if (i == WIDTH - 1) begin
                if (coincide) cs = 1'b1;
                sclk = 1'b1;
                for (int k = 0; k < PH; k++) begin
                    if (ready_pulse && k == D) out_if.dout_ready = 1'b1;
                    cyc(1);
                    if (ready_pulse && k == D) out_if.dout_ready = 1'b0;
                    if (chk_lat && seen && k == lat)
                        check("valid_clears", 32'(out_if.dout_valid), 32'd0);
                    if (chk_lat && !seen && out_if.dout_valid) begin
                        seen = 1'b1;
                        lat  = k + 1;
                        check("word_on_edge", 32'(out_if.dout), 32'(w));
                    end
                end
                if (chk_lat) check("latency", 32'(lat), 32'(D + 1));
            end else begin
                sclk = 1'b1;
                cyc(PH);
            end
        end
        sclk = 1'b0;
        cyc(PH);
        repeat (extra) begin
            mosi = 1'($urandom);
            sclk = 1'b1;
            cyc(PH);
            sclk = 1'b0;
            cyc(PH);
        end
        cs = 1'b1;
        cyc(PH + 2);
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        int nb;
        rst = 1'b0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
        out_if.dout_ready = 1'b0;
        exp_dout = '0; exp_valid = 1'b0; exp_fe = 0; exp_ov = 0; rdy = 1'b0;
        cyc(3);
        check_state("reset");
        rst = 1'b1;
        cyc(3);
        check_state("post_reset");

        rdy = 1'b1; out_if.dout_ready = 1'b1;
        send_frame(12'hA5C, WIDTH, 1'b0, 0, 1'b1, 1'b0);
        model_frame(12'hA5C, WIDTH, 1'b1);
        check_state("a5c");

        rdy = 1'b0; out_if.dout_ready = 1'b0;
        send_frame(12'h123, WIDTH, 1'b0, 0, 1'b0, 1'b0);
        model_frame(12'h123, WIDTH, 1'b0);
        send_frame(12'hFFF, WIDTH, 1'b0, 0, 1'b0, 1'b0);
        model_frame(12'hFFF, WIDTH, 1'b0);
        check_state("overrun");

        rdy = 1'b1; out_if.dout_ready = 1'b1;
        cyc(2);
        rdy = 1'b0; out_if.dout_ready = 1'b0;
        exp_valid = 1'b0;
        send_frame(12'h123, WIDTH, 1'b0, 0, 1'b0, 1'b0);
        model_frame(12'h123, WIDTH, 1'b0);
        send_frame(12'hFFF, WIDTH, 1'b0, 0, 1'b0, 1'b1);
        model_frame(12'hFFF, WIDTH, 1'b1);
        check_state("ready_on_completion");

        send_frame(12'h07F, 7, 1'b0, 0, 1'b0, 1'b0);
        model_frame(12'h07F, 7, 1'b0);
        check_state("short_frame");
        rdy = 1'b1; out_if.dout_ready = 1'b1;
        send_frame(12'h001, WIDTH, 1'b0, 0, 1'b0, 1'b0);
        model_frame(12'h001, WIDTH, 1'b1);
        check_state("after_short");

        send_frame(12'h800, WIDTH, 1'b1, 0, 1'b1, 1'b0);
        model_frame(12'h800, WIDTH, 1'b1);
        check_state("cs_coincident");

        rdy = 1'b0; out_if.dout_ready = 1'b0;
        send_frame(12'h3C7, WIDTH, 1'b0, 3, 1'b0, 1'b0);
        model_frame(12'h3C7, WIDTH, 1'b0);
        check_state("wait_cs_extra");

        rdy = 1'b1; out_if.dout_ready = 1'b1;
        cs = 1'b0;
        cyc(PH);
        for (int i = 0; i < 5; i++) begin
            mosi = 1'($urandom);
            sclk = 1'b0;
            cyc(PH);
            sclk = 1'b1;
            cyc(PH);
        end
        check("busy_mid_frame", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        exp_dout = '0; exp_valid = 1'b0;
        check_state("async_reset");
        cs = 1'b1; sclk = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(PH);
        send_frame(12'h5A5, WIDTH, 1'b0, 0, 1'b1, 1'b0);
        model_frame(12'h5A5, WIDTH, 1'b1);
        check_state("after_reset");

        for (int n = 0; n < 16; n++) begin
            rdy = 1'($urandom);
            out_if.dout_ready = rdy;
            cyc(2);
            w  = WIDTH'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, WIDTH - 1)) : WIDTH;
            send_frame(w, nb, 1'b0, 0, 1'b0, 1'b0);
            model_frame(w, nb, rdy);
            check_state("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_rx.md
# spi_rx

SPI receive stage that sits directly downstream of the 12-bit SPI transmitter and consumes its `sclk`, `cs` and `mosi` lines. It synchronises the serial lines into the system clock domain and detects `sclk` rising edges. It deserialises one LSB-first 12-bit word per chip-select frame and presents the word on a valid/ready parallel interface. Framing errors and overruns are flagged.

## Interface
- `WIDTH`, 12: bits per frame; also the width of `dout`.
- `clk`, input, 1: system clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `sclk`, input, 1: serial clock from the transmitter; asynchronous to `clk`.
- `cs`, input, 1: active-low chip select; asynchronous to `clk`.
- `mosi`, input, 1: serial data, LSB first; asynchronous to `clk`.
- `dout`, output, WIDTH: last received word.
- `dout_valid`, output, 1: `dout` holds an unconsumed word.
- `dout_ready`, input, 1: consumer accepts `dout`.
- `busy`, output, 1: a frame is in progress (state RECV or WAIT_CS).
- `frame_err`, output, 1: one-cycle pulse when `cs` deasserts before WIDTH bits have been received.
- `overrun`, output, 1: one-cycle pulse when a completed word is dropped.

## Operation
- Input path:
  - `sclk`, `cs` and `mosi` each pass through a synchroniser of depth D; D is set in Configuration.
  - Synchronised values are `sclk_s`, `cs_s` and `mosi_s`.
  - `sclk_d` is `sclk_s` delayed by one cycle.
  - A rising edge (`rise`) is `sclk_s & ~sclk_d`.
- Reset values (`rst`=0, asynchronous):
  - Synchroniser and edge flops: sclk 0, cs 1, mosi 0.
  - State IDLE, bit counter 0, shift register 0.
  - `dout` 0, `dout_valid` 0, `busy` 0, `frame_err` 0, `overrun` 0.
- FSM:
  - IDLE: when `cs_s`=0, go to RECV and clear the counter. `rise` in IDLE is ignored.
  - RECV, on `rise`: store `mosi_s` into shift bit [count], then count+1.
  - RECV, on the `rise` that brings count to WIDTH: perform the word-completion action below, then go to WAIT_CS.
  - RECV, `cs_s`=1 with no completing `rise` that cycle: pulse `frame_err`, discard the partial word, go to IDLE. `dout` is unchanged.
  - WAIT_CS: ignore all `rise`. When `cs_s`=1, go to IDLE.
- Simultaneous `rise` (WIDTH-th bit) and `cs_s`=1 in the same cycle: the word completes, there is no `frame_err`, and the next state is IDLE.
- Counter width is clog2(WIDTH+1). Bit i of the frame lands in `dout[i]`; the first bit is the LSB.
- Word-completion action:
  - If `dout_valid`=0, or `dout_valid`=1 with `dout_ready`=1 that cycle: `dout` <= assembled word and `dout_valid` <= 1.
  - Otherwise (`dout_valid`=1, `dout_ready`=0): `dout` and `dout_valid` are held, the new word is dropped, and `overrun` pulses.
- Handshake:
  - A transfer occurs on a `clk` edge where `dout_valid`=1 and `dout_ready`=1.
  - On a transfer, `dout_valid` clears unless a word completes on the same edge.
  - `dout` is stable while `dout_valid`=1.
  - `dout_ready` is a don't-care while `dout_valid`=0.

## Timing
- Edge-detect latency: a pin-level `sclk` rise becomes visible as `rise` D cycles after the first `clk` edge that samples it. `mosi` sees the same delay, so it is aligned with `rise`.
- Shift and completion updates are registered on the `clk` edge where `rise` is high.
- `dout` and `dout_valid` update on that same edge: 0 extra cycles after the final `rise`.
- `frame_err` and `overrun` are high for exactly one cycle, registered.
- Transmitter constraint: the `sclk` high and low phases must each be at least 2 `clk` cycles. `mosi` must be stable for D+1 cycles around each `sclk` rise.
- Reset asserted mid-frame: everything returns to reset values immediately. After release, the block waits in IDLE for the next `cs_s` falling level.

## Configuration
- `SPI_RX_SYNC2_EN` defined: D=2, a two-flop metastability synchroniser on each input. This is required when the transmitter runs from an unrelated clock.
- `SPI_RX_SYNC2_EN` undefined: D=1, a single register stage. Use this only when the transmitter shares `clk`. Latency drops by one cycle.
- All other behaviour is identical in both builds.

## Test plan
- 12-bit frame 0xA5C sent LSB first, `dout_ready`=1: `dout`=0xA5C and `dout_valid`=1 on the edge of the 12th `rise`. `dout_valid` clears the next cycle. No `frame_err` or `overrun`.
- Two frames 0x123 then 0xFFF with `dout_ready`=0: `dout` stays 0x123, `overrun` pulses once at the second completion, and `dout_valid` stays 1.
- Repeat the previous case with `dout_ready`=1 on the exact second-completion edge: `dout`=0xFFF, `dout_valid`=1, no `overrun`.
- `cs` raised after 7 bits: `frame_err` pulses once, `dout` and `dout_valid` are unchanged, state returns to IDLE. The following full frame 0x001 is received correctly.
- `cs` rise coincident with the 12th `rise` (value 0x800): the word is accepted, no `frame_err`. Then 3 extra `sclk` pulses while `cs` is low in WAIT_CS: these are ignored, with no new word.
- `rst` pulsed low after bit 5 of a frame: all outputs are 0 immediately and `busy`=0. The next frame 0x5A5 completes correctly. Run this case in both `SPI_RX_SYNC2_EN` builds and check the latency difference of 1 cycle.
